// File: rtl/ip_spi_pkg.sv
// Shared types and constants for the SPI frame slave.
package ip_spi_pkg;

  // Frame-level state of the slave
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_END    = 2'd2
  } spi_state_t;

  // SPI modes: bit1 = CPOL (idle clock level), bit0 = CPHA (sample on trailing edge)
  localparam int MODE0 = 0;
  localparam int MODE1 = 1;
  localparam int MODE2 = 2;
  localparam int MODE3 = 3;

  // Response word used when the host has not loaded anything
  localparam logic [7:0] IDLE_RESP_DEFAULT = 8'hA5;

  function automatic logic mode_cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input int mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/ip_spi_sync.sv
// Two-flop synchronizer followed by a one-flop edge detector for a single
// asynchronous input. The reset level lets each input start at its idle value
// so that reset release does not fabricate an edge on an idle line.
module ip_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronizer chain plus the history flop used for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/ip_spi_frame_slave.sv
// SPI slave that frames words between chip-select edges. All SPI pins are
// oversampled by the system clock; every action happens on clk.
//
// Handshake: tx_valid/tx_ready follow valid/ready semantics -- a word is
// accepted on any clk edge where both are high; tx_ready is high exactly when
// the one-word holding register is empty. rx_valid is a one-cycle pulse with
// no back-pressure; rx_data/rx_index stay stable until the next pulse.
module ip_spi_frame_slave
  import ip_spi_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                SPI_MODE  = 3,
  parameter logic [DATA_W-1:0] IDLE_RESP = DATA_W'(IDLE_RESP_DEFAULT),
  parameter int                IDX_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [IDX_W-1:0]  rx_index,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_start,
  output logic              frame_end,
  output logic              tx_underrun,
  output spi_state_t        fsm_state
);

  localparam logic CPOL  = mode_cpol(SPI_MODE);
  localparam logic CPHA  = mode_cpha(SPI_MODE);
  localparam int   CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // ---------------------------------------------------------------------------
  // Input synchronization. All three pins see the same pipeline depth, so the
  // mosi level seen together with a clock edge is the one the master set up.
  // ---------------------------------------------------------------------------
  logic       cs_level;
  logic       cs_rise;
  logic       cs_fall;
  logic       sclk_level_unused;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       mosi_level;
  logic [1:0] mosi_edges_unused;

  ip_spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .d     (spi_cs_n),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  ip_spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .d     (spi_clk),
    .level (sclk_level_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  ip_spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .d     (spi_mosi),
    .level (mosi_level),
    .rise  (mosi_edges_unused[1]),
    .fall  (mosi_edges_unused[0])
  );

  // Leading edge is the edge away from the idle level; CPHA picks which of
  // the two edges samples mosi, the other one advances miso.
  logic sample_edge;
  logic shift_edge;

  assign sample_edge = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign shift_edge  = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;

  // ---------------------------------------------------------------------------
  // Arming. The synchronizers reset to CS high; if CS is really low when reset
  // releases, the pipeline would show a false fall. A CS fall is accepted only
  // after the pipeline has flushed and CS has been seen high.
  // ---------------------------------------------------------------------------
  logic [1:0] settle;
  logic       armed;

  // Flush counter and arm flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle <= 2'd0;
      armed  <= 1'b0;
    end else if (settle != 2'd3) begin
      settle <= settle + 2'd1;
    end else if (cs_level) begin
      armed <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  spi_state_t state;
  spi_state_t state_next;
  logic       active;
  logic       start_evt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: CS edges drive the frame; END lasts one clk
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cs_fall && armed) state_next = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise)          state_next = ST_END;
      ST_END:    state_next = (cs_fall && armed) ? ST_ACTIVE : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode of the FSM
  always_comb begin
    active    = (state == ST_ACTIVE);
    frame_end = (state == ST_END);
    start_evt = (state != ST_ACTIVE) && (state_next == ST_ACTIVE);
    fsm_state = state;
  end

  // ---------------------------------------------------------------------------
  // Word timing. Clock edges are ignored outside ACTIVE and on the clk where
  // CS rises, so a late edge cannot complete a word after deselect.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] word_idx;
  logic             in_word;
  logic             do_sample;
  logic             do_shift;
  logic             word_done;
  logic             tx_load;

  assign in_word   = active && !cs_rise;
  assign do_sample = in_word && sample_edge;
  assign do_shift  = in_word && shift_edge;
  assign word_done = do_sample && (bit_cnt == LAST_BIT);
  // A word starts at CS fall for CPHA=0, and at every shift edge that finds
  // the bit counter at zero (first edge of a CPHA=1 word, or the edge after
  // the last sample of a CPHA=0 word).
  assign tx_load   = (start_evt && !CPHA) || (do_shift && (bit_cnt == '0));

  // Bit counter and in-frame word index; cleared at frame start and on deselect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      word_idx <= '0;
    end else if (start_evt || (active && cs_rise)) begin
      bit_cnt  <= '0;
      word_idx <= '0;
    end else if (do_sample) begin
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      if (word_done && (word_idx != '1)) begin
        word_idx <= word_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_shift;

  // MOSI shifter and word publication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_shift <= '0;
      rx_data  <= '0;
      rx_index <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (do_sample) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_level};
      end
      if (word_done) begin
        rx_data  <= {rx_shift[DATA_W-2:0], mosi_level};
        rx_index <= word_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit path
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic [DATA_W-1:0] tx_shift;

  assign tx_ready = !hold_full;

  // Holding register: a host write wins over a same-clk drain because a
  // write is only possible while the register is already empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end else if (tx_load) begin
      hold_full <= 1'b0;
    end
  end

  // MISO shifter: reload at word start, otherwise advance on shift edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift <= '1;
    end else if (tx_load) begin
      tx_shift <= hold_full ? hold : IDLE_RESP;
    end else if (do_shift) begin
      tx_shift <= {tx_shift[DATA_W-2:0], 1'b1};
    end
  end

  // Frame-start pulse and sticky underrun; a substitution on the very clk of
  // frame start still leaves the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      frame_start <= start_evt;
      if (tx_load && !hold_full) begin
        tx_underrun <= 1'b1;
      end else if (start_evt) begin
        tx_underrun <= 1'b0;
      end
    end
  end

  assign spi_miso = active ? tx_shift[DATA_W-1] : 1'b1;

endmodule

// File: tb/tb_ip_spi_frame_slave.sv
// Bench for ip_spi_frame_slave: instance a is the default MODE3/8-bit slave,
// instance b is a MODE0/16-bit slave. Received words are predicted into
// per-instance queues and checked by monitors as rx_valid appears.
`timescale 1ns/1ps
module tb_ip_spi_frame_slave;
  import ip_spi_pkg::*;

  localparam int H = 8;  // SPI half period in clk cycles

  typedef logic [15:0] word_arr_t [4];

  logic clk;
  logic reset;

  // instance a signals
  logic        cs_a, sclk_a, mosi_a, miso_a;
  logic [7:0]  rx_data_a, tx_data_a;
  logic        rx_valid_a, tx_valid_a, tx_ready_a;
  logic [15:0] rx_index_a;
  logic        fs_a, fe_a, und_a;
  spi_state_t  st_a;

  // instance b signals
  logic        cs_b, sclk_b, mosi_b, miso_b;
  logic [15:0] rx_data_b, tx_data_b;
  logic        rx_valid_b, tx_valid_b, tx_ready_b;
  logic [15:0] rx_index_b;
  logic        fs_b, fe_b, und_b;
  spi_state_t  st_b;

  int checks;
  int errors;
  int fs_cnt_a, fe_cnt_a, rx_cnt_a;
  int fs_cnt_b, fe_cnt_b, rx_cnt_b;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  ip_spi_frame_slave dut_a (
    .clk(clk), .reset(reset), .spi_cs_n(cs_a), .spi_clk(sclk_a), .spi_mosi(mosi_a),
    .spi_miso(miso_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_index(rx_index_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .frame_start(fs_a), .frame_end(fe_a), .tx_underrun(und_a), .fsm_state(st_a)
  );

  ip_spi_frame_slave #(.DATA_W(16), .SPI_MODE(MODE0)) dut_b (
    .clk(clk), .reset(reset), .spi_cs_n(cs_b), .spi_clk(sclk_b), .spi_mosi(mosi_b),
    .spi_miso(miso_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_index(rx_index_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .frame_start(fs_b), .frame_end(fe_b), .tx_underrun(und_b), .fsm_state(st_b)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // monitors: pulse counting and scoreboard
  always @(negedge clk) begin
    if (fs_a) fs_cnt_a++;
    if (fe_a) fe_cnt_a++;
    if (fs_b) fs_cnt_b++;
    if (fe_b) fe_cnt_b++;
    if (rx_valid_a) begin
      rx_cnt_a++;
      if (exp_a_q.size() == 0) begin
        check("rx a unexpected word", {rx_index_a, 8'h00, rx_data_a}, 32'hFFFF_FFFF);
      end else begin
        check("rx a word", {rx_index_a, 8'h00, rx_data_a}, exp_a_q.pop_front());
      end
    end
    if (rx_valid_b) begin
      rx_cnt_b++;
      if (exp_b_q.size() == 0) begin
        check("rx b unexpected word", {rx_index_b, rx_data_b}, 32'hFFFF_FFFF);
      end else begin
        check("rx b word", {rx_index_b, rx_data_b}, exp_b_q.pop_front());
      end
    end
  end

  // one SPI word as master; a = MODE3, b = MODE0; returns captured miso
  task automatic spi_word(input int inst, input logic [15:0] data, input int nbits,
                          output logic [15:0] got);
    got = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (inst == 0) begin
        sclk_a = 1'b0;
        mosi_a = data[i];
        wait_clks(H);
        sclk_a = 1'b1;
        got = {got[14:0], miso_a};
        wait_clks(H);
      end else begin
        mosi_b = data[i];
        wait_clks(H);
        sclk_b = 1'b1;
        got = {got[14:0], miso_b};
        wait_clks(H);
        sclk_b = 1'b0;
      end
    end
  endtask

  task automatic set_cs(input int inst, input logic v);
    if (inst == 0) cs_a = v;
    else cs_b = v;
  endtask

  // full frame: predicts rx words, checks miso; optional host load after a word
  task automatic frame(input int inst, input int nwords, input word_arr_t words,
                       input word_arr_t miso_exp, input int load_after,
                       input logic [7:0] load_val);
    logic [15:0] got;
    int nb;
    nb = (inst == 0) ? 8 : 16;
    set_cs(inst, 1'b0);
    wait_clks(H);
    for (int w = 0; w < nwords; w++) begin
      if (inst == 0) exp_a_q.push_back({16'(w), words[w]});
      else exp_b_q.push_back({16'(w), words[w]});
      spi_word(inst, words[w], nb, got);
      check($sformatf("miso inst%0d word%0d", inst, w), {16'h0, got}, {16'h0, miso_exp[w]});
      if (w == load_after) begin
        wait_clks(6);
        check("tx_ready after hold drained", {31'h0, tx_ready_a}, 32'h1);
        tx_data_a  = load_val;
        tx_valid_a = 1'b1;
        wait_clks(1);
        tx_valid_a = 1'b0;
        check("tx_ready after load", {31'h0, tx_ready_a}, 32'h0);
      end
    end
    wait_clks(H);
    set_cs(inst, 1'b1);
    wait_clks(2 * H);
  endtask

  task automatic check_reset_outputs_a(input string tag);
    check({tag, " rx_data"},  {24'h0, rx_data_a}, 32'h0);
    check({tag, " rx_index"}, {16'h0, rx_index_a}, 32'h0);
    check({tag, " flags"}, {27'h0, rx_valid_a, fs_a, fe_a, und_a, tx_ready_a}, 32'h1);
    check({tag, " miso"}, {31'h0, miso_a}, 32'h1);
    check({tag, " state"}, {30'h0, st_a}, {30'h0, ST_IDLE});
  endtask

  // stimulus
  initial begin
    int fs0, fe0, rx0;
    logic [15:0] dummy;
    checks = 0; errors = 0;
    fs_cnt_a = 0; fe_cnt_a = 0; rx_cnt_a = 0;
    fs_cnt_b = 0; fe_cnt_b = 0; rx_cnt_b = 0;
    reset = 1'b1;
    cs_a = 1'b1; sclk_a = 1'b1; mosi_a = 1'b0; tx_data_a = '0; tx_valid_a = 1'b0;
    cs_b = 1'b1; sclk_b = 1'b0; mosi_b = 1'b0; tx_data_b = '0; tx_valid_b = 1'b0;
    wait_clks(5);
    check_reset_outputs_a("reset a");
    check("reset b flags", {27'h0, rx_valid_b, fs_b, fe_b, und_b, tx_ready_b}, 32'h1);
    check("reset b miso", {31'h0, miso_b}, 32'h1);
    reset = 1'b0;
    wait_clks(10);

    // single 0x00 word, idle response with underrun
    frame(0, 1, '{16'h00, 16'h0, 16'h0, 16'h0}, '{16'hA5, 16'h0, 16'h0, 16'h0}, -1, 8'h0);
    check("underrun after empty word", {31'h0, und_a}, 32'h1);

    // three-word frame; one start and one end pulse
    fs0 = fs_cnt_a; fe0 = fe_cnt_a;
    frame(0, 3, '{16'h03, 16'h05, 16'hFF, 16'h0}, '{16'hA5, 16'hA5, 16'hA5, 16'h0}, -1, 8'h0);
    check("frame_start pulses", fs_cnt_a - fs0, 1);
    check("frame_end pulses", fe_cnt_a - fe0, 1);
    check("rx index held", {16'h0, rx_index_a}, 32'h2);

    // preload 0x5A, ignored write while full, 0x3C loaded after first word
    tx_data_a = 8'h5A; tx_valid_a = 1'b1;
    wait_clks(1);
    tx_valid_a = 1'b0;
    check("tx_ready low after preload", {31'h0, tx_ready_a}, 32'h0);
    tx_data_a = 8'h77; tx_valid_a = 1'b1;
    wait_clks(1);
    tx_valid_a = 1'b0;
    frame(0, 2, '{16'h11, 16'h22, 16'h0, 16'h0}, '{16'h5A, 16'h3C, 16'h0, 16'h0}, 0, 8'h3C);
    check("no underrun with loaded words", {31'h0, und_a}, 32'h0);
    check("tx_ready after frame", {31'h0, tx_ready_a}, 32'h1);

    // CS raised after 5 bits: no word, frame_end pulses
    fs0 = fs_cnt_a; fe0 = fe_cnt_a; rx0 = rx_cnt_a;
    cs_a = 1'b0;
    wait_clks(H);
    spi_word(0, 16'h1F, 5, dummy);
    wait_clks(H);
    cs_a = 1'b1;
    wait_clks(2 * H);
    check("partial no rx_valid", rx_cnt_a - rx0, 0);
    check("partial frame_end", fe_cnt_a - fe0, 1);
    check("partial frame_start", fs_cnt_a - fs0, 1);
    frame(0, 1, '{16'h81, 16'h0, 16'h0, 16'h0}, '{16'hA5, 16'h0, 16'h0, 16'h0}, -1, 8'h0);

    // reset mid-word
    fe0 = fe_cnt_a; rx0 = rx_cnt_a;
    cs_a = 1'b0;
    wait_clks(H);
    spi_word(0, 16'h07, 3, dummy);
    reset = 1'b1;
    wait_clks(3);
    check_reset_outputs_a("mid reset a");
    reset = 1'b0;
    wait_clks(4);
    cs_a = 1'b1;
    wait_clks(2 * H);
    check("no frame_end from reset", fe_cnt_a - fe0, 0);
    check("no rx from reset", rx_cnt_a - rx0, 0);
    frame(0, 1, '{16'h06, 16'h0, 16'h0, 16'h0}, '{16'hA5, 16'h0, 16'h0, 16'h0}, -1, 8'h0);

    // MODE0, 16-bit word
    frame(1, 1, '{16'h1234, 16'h0, 16'h0, 16'h0}, '{16'h00A5, 16'h0, 16'h0, 16'h0}, -1, 8'h0);
    check("b underrun", {31'h0, und_b}, 32'h1);
    check("b frame_start pulses", fs_cnt_b, 1);
    check("b frame_end pulses", fe_cnt_b, 1);

    // final: holds and drained scoreboard
    wait_clks(10);
    check("rx_data a holds", {24'h0, rx_data_a}, 32'h06);
    check("rx_index a holds", {16'h0, rx_index_a}, 32'h0);
    check("a words outstanding", exp_a_q.size(), 0);
    check("b words outstanding", exp_b_q.size(), 0);
    check("a word count", rx_cnt_a, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
